// File: rtl/bcd_time_display_scan.sv
// rtl/bcd_time_display_scan.sv - multiplexed 6-digit seven-segment scanner for a BCD hh:mm:ss clock
//
// Purpose:
//    Takes a coherent snapshot of the six BCD time digits once per scan
//    frame and drives a common-anode, time-multiplexed 6-digit display.
//    Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYC cycles of
//    every slot keep all anodes off so the previous digit's segments do not
//    ghost onto the next one. Digits above 9 are shown as a dash. With LZB
//    set, a leading hour zero is blanked. Separator points after the hours
//    and minutes blink with bit 0 of the seconds units.
//
// Parameters:
//    SCAN_DIV   clock cycles per digit slot (>= 2)
//    BLANK_CYC  leading cycles of each slot with all anodes off (< SCAN_DIV)
//    LZB        1 = blank ms_hr when it is 0
//
// Ports:
//    clk          system clock, all state on the rising edge
//    reset        synchronous, active-high reset
//    enable       1 = scan runs, 0 = hold all state and blank the display
//    ms_hr..ls_sec  BCD time digits from the clock counter
//    an           digit anodes, active-low, bit k = digit k
//                 (0=ls_sec, 1=ms_sec, 2=ls_min, 3=ms_min, 4=ls_hr, 5=ms_hr)
//    seg          segments {g,f,e,d,c,b,a}, active-low
//    dp           decimal point, active-low
//    frame_start  one-cycle pulse in the cycle after the snapshot loads

module bcd_time_display_scan #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 2,
   parameter int LZB       = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] ms_hr,
   input  logic [3:0] ls_hr,
   input  logic [3:0] ms_min,
   input  logic [3:0] ls_min,
   input  logic [3:0] ms_sec,
   input  logic [3:0] ls_sec,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);

   localparam logic [2:0] IDX_LAST   = 3'd5;
   localparam logic [2:0] IDX_LS_MIN = 3'd2;
   localparam logic [2:0] IDX_LS_HR  = 3'd4;
   localparam logic [2:0] IDX_MS_HR  = 3'd5;

   localparam logic [5:0] AN_OFF   = 6'b111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // Active-low segment patterns, {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   snap_q, snap_d;          // digit k lives in [4k+3:4k]
   logic          load_pending_q, load_pending_d;
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_start_q, frame_start_d;

   // ------------------------------------------------------------------
   // Scan timing and snapshot control
   // ------------------------------------------------------------------
   logic presc_term;
   logic frame_wrap;
   logic snap_load;

   always_comb begin
      presc_term     = (presc_q == PRESC_LAST);
      frame_wrap     = presc_term && (idx_q == IDX_LAST);
      // The very first enabled cycle after reset loads too, so the display
      // never shows the all-zero reset snapshot for a whole frame.
      snap_load      = enable && (load_pending_q || frame_wrap);

      presc_d        = presc_q;
      idx_d          = idx_q;
      load_pending_d = load_pending_q;

      if (enable) begin
         load_pending_d = 1'b0;
         if (presc_term) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      snap_d        = snap_load ? {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec}
                                : snap_q;
      frame_start_d = snap_load;
   end

   // ------------------------------------------------------------------
   // Digit select and segment decode
   // ------------------------------------------------------------------
   logic [3:0] cur_digit;
   logic [6:0] cur_pattern;
   logic       slot_blank;
   logic       lead_zero;
   logic       sep_slot;

   always_comb begin
      cur_digit = 4'h0;
      case (idx_q)
         3'd0:    cur_digit = snap_q[3:0];
         3'd1:    cur_digit = snap_q[7:4];
         3'd2:    cur_digit = snap_q[11:8];
         3'd3:    cur_digit = snap_q[15:12];
         3'd4:    cur_digit = snap_q[19:16];
         3'd5:    cur_digit = snap_q[23:20];
         default: cur_digit = 4'h0;
      endcase

      cur_pattern = SEG_DASH;
      case (cur_digit)
         4'd0:    cur_pattern = SEG_0;
         4'd1:    cur_pattern = SEG_1;
         4'd2:    cur_pattern = SEG_2;
         4'd3:    cur_pattern = SEG_3;
         4'd4:    cur_pattern = SEG_4;
         4'd5:    cur_pattern = SEG_5;
         4'd6:    cur_pattern = SEG_6;
         4'd7:    cur_pattern = SEG_7;
         4'd8:    cur_pattern = SEG_8;
         4'd9:    cur_pattern = SEG_9;
         default: cur_pattern = SEG_DASH;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered output drive, computed from the current state so the pins
   // trail the scan state by one cycle.
   // ------------------------------------------------------------------
   always_comb begin
      // Index values above 5 cannot occur, but treat them as blank so the
      // anodes and segments always agree.
      slot_blank = !enable || (presc_q < PRESC_BLANK) || (idx_q > IDX_LAST);
      lead_zero  = (LZB != 0) && (idx_q == IDX_MS_HR) && (snap_q[23:20] == 4'h0);
      sep_slot   = (idx_q == IDX_LS_MIN) || (idx_q == IDX_LS_HR);

      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;

      if (!slot_blank) begin
         an_d  = ~(6'b000001 << idx_q);
         seg_d = lead_zero ? SEG_OFF : cur_pattern;
         // Separators light on even seconds, so they blink at half rate.
         dp_d  = !(sep_slot && !snap_q[0]);
      end
   end

   // ------------------------------------------------------------------
   // Flops
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q        <= '0;
         idx_q          <= 3'd0;
         snap_q         <= '0;
         load_pending_q <= 1'b1;
         an_q           <= AN_OFF;
         seg_q          <= SEG_OFF;
         dp_q           <= 1'b1;
         frame_start_q  <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         idx_q          <= idx_d;
         snap_q         <= snap_d;
         load_pending_q <= load_pending_d;
         an_q           <= an_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule
